// File: rtl/calc_engine_param.sv
// calc_engine_param: keypad-driven infix calculator with operand/operator stacks,
// one reduction per clock, busy/ready handshake and a character display buffer
module calc_engine_param #(
  parameter int DATA_W = 32,
  parameter int STACK_DEPTH = 8,
  parameter int DISP_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_valid,
  input  logic [7:0] btn_char,
  output logic btn_ready,
  output logic busy,
  output logic [8*DISP_LEN-1:0] disp_str_flat,
  output logic [DATA_W-1:0] input_val,
  output logic [DATA_W-1:0] result_value,
  output logic result_valid,
  output logic error
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int DIW = $clog2(DISP_LEN + 1);
  localparam int SD = 1 << SPW;
  localparam int DD = 1 << DIW;
  typedef enum logic [2:0] {S_ENTRY, S_REDUCE, S_FINAL, S_DONE, S_ERR} state_t;
  state_t state;
  logic [DATA_W-1:0] opnd [SD];
  logic [1:0] opst [SD];
  logic [7:0] disp [DD];
  logic [SPW-1:0] osp, psp;
  logic [DIW-1:0] disp_index;
  logic [15:0] digit_cnt;
  logic digit_seen;
  logic [1:0] pend, key_op, top_op;
  logic accept, is_digit, is_op, is_eq, is_clr, is_bs, app, div0, unwind;
  logic [DATA_W-1:0] d, a, b, red;
  // op codes: 0 '+', 1 '-', 2 '*', 3 '/'; bit 1 is the precedence level
  always_comb begin
    busy = state == S_REDUCE || state == S_FINAL;
    btn_ready = !busy;
    accept = btn_valid && !busy;
    is_digit = btn_char >= "0" && btn_char <= "9";
    is_op = btn_char == "+" || btn_char == "-" || btn_char == "*" || btn_char == "/";
    is_eq = btn_char == "=";
    is_clr = btn_char == "C";
    is_bs = btn_char == 8'h08;
    key_op = btn_char == "+" ? 2'd0 : btn_char == "-" ? 2'd1 : btn_char == "*" ? 2'd2 : 2'd3;
    d = DATA_W'(btn_char - 8'd48);
    a = opnd[osp - SPW'(2)];
    b = opnd[osp - SPW'(1)];
    top_op = opst[psp - SPW'(1)];
    div0 = top_op == 2'd3 && b == '0;
    red = top_op == 2'd0 ? a + b : top_op == 2'd1 ? a - b : top_op == 2'd2 ? a * b : (div0 ? '0 : a / b);
    unwind = psp == SPW'(1) || opst[psp - SPW'(2)][1] < pend[1];
    app = accept && state == S_ENTRY && (is_digit || ((is_op || is_eq) && digit_seen))
          && disp_index != DIW'(DISP_LEN);
    for (int i = 0; i < DISP_LEN; i++) disp_str_flat[8*i +: 8] = disp[i];
  end
  always_ff @(posedge clk) begin
    result_valid <= 1'b0;
    if (rst || (accept && is_clr && state != S_REDUCE && state != S_FINAL)) begin
      state <= S_ENTRY;
      osp <= '0;
      psp <= '0;
      pend <= '0;
      input_val <= '0;
      result_value <= '0;
      error <= 1'b0;
      digit_seen <= 1'b0;
      digit_cnt <= '0;
      disp_index <= '0;
      for (int i = 0; i < SD; i++) begin
        opnd[i] <= '0;
        opst[i] <= '0;
      end
      for (int i = 0; i < DD; i++) disp[i] <= " ";
    end else begin
      if (app) begin
        disp[disp_index] <= btn_char;
        disp_index <= disp_index + DIW'(1);
      end
      case (state)
        S_ENTRY: if (accept) begin
          if (is_digit) begin
            input_val <= input_val * DATA_W'(10) + d;
            digit_seen <= 1'b1;
            digit_cnt <= digit_cnt + 16'd1;
          end else if (is_bs && digit_seen) begin
            input_val <= input_val / DATA_W'(10);
            digit_cnt <= digit_cnt - 16'd1;
            digit_seen <= digit_cnt != 16'd1;
            if (disp_index != '0) begin
              disp[disp_index - DIW'(1)] <= " ";
              disp_index <= disp_index - DIW'(1);
            end
          end else if ((is_op || is_eq) && digit_seen) begin
            input_val <= '0;
            digit_seen <= 1'b0;
            digit_cnt <= '0;
            if (osp == SPW'(STACK_DEPTH)) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              opnd[osp] <= input_val;
              osp <= osp + SPW'(1);
              if (is_eq) state <= S_FINAL;
              else if (psp != '0 && top_op[1] >= key_op[1]) begin
                pend <= key_op;
                state <= S_REDUCE;
              end else if (psp == SPW'(STACK_DEPTH)) begin
                error <= 1'b1;
                state <= S_ERR;
              end else begin
                opst[psp] <= key_op;
                psp <= psp + SPW'(1);
              end
            end
          end
        end
        S_REDUCE: if (div0) begin
          error <= 1'b1;
          state <= S_ERR;
        end else begin
          opnd[osp - SPW'(2)] <= red;
          osp <= osp - SPW'(1);
          psp <= unwind ? psp : psp - SPW'(1);
          if (unwind) begin
            opst[psp - SPW'(1)] <= pend;
            state <= S_ENTRY;
          end
        end
        S_FINAL: if (psp == '0) begin
          result_value <= opnd[0];
          result_valid <= 1'b1;
          state <= S_DONE;
        end else if (div0) begin
          error <= 1'b1;
          state <= S_ERR;
        end else begin
          opnd[osp - SPW'(2)] <= red;
          osp <= osp - SPW'(1);
          psp <= psp - SPW'(1);
        end
        S_DONE: if (accept && (is_digit || is_op)) begin
          for (int i = 0; i < DD; i++) disp[i] <= " ";
          disp[0] <= btn_char;
          disp_index <= DIW'(1);
          state <= S_ENTRY;
          opnd[0] <= result_value;
          osp <= is_op ? SPW'(1) : '0;
          opst[0] <= key_op;
          psp <= is_op ? SPW'(1) : '0;
          input_val <= is_op ? '0 : d;
          digit_seen <= !is_op;
          digit_cnt <= is_op ? 16'd0 : 16'd1;
        end
        S_ERR: ;
        default: state <= S_ENTRY;
      endcase
    end
  end
endmodule
